// File: rtl/avalon_bus_pkg.sv
// Shared Avalon bus types plus the CSR bridge state encoding and the
// elaboration-time data-width legality check.
package avalon_bus_pkg;

   typedef enum logic [1:0] {
      OKAY         = 2'b00,
      RESERVED     = 2'b01,
      SLAVE_ERROR  = 2'b10,
      DECODE_ERROR = 2'b11
   } response_te;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } csr_bridge_state_te;

   function automatic logic legal_dwidth(input int w);
      return (w == 8) || (w == 16) || (w == 32) || (w == 64) || (w == 128);
   endfunction

endpackage

// File: rtl/avalon_csr_timeout.sv
// WAIT-state watchdog for avalon_csr_bridge: cleared by start, counts while
// run is high, and flags expiry on the TIMEOUT-th counted cycle.
module avalon_csr_timeout
   import avalon_bus_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (start) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   // count holds the number of WAIT cycles already spent before this one
   assign expired = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/avalon_csr_bridge.sv
// Avalon-MM slave to CSR block bridge: one command at a time, window decode,
// single-cycle register strobe. Optional WAIT watchdog: AVALON_CSR_TIMEOUT_EN.
module avalon_csr_bridge
   import avalon_bus_pkg::*;
#(
   parameter int              AWIDTH    = 20,
   parameter int              DWIDTH    = 64,
   parameter int              BE_WIDTH  = DWIDTH / 8,
   parameter longint unsigned BASE_ADDR = 0,
   parameter longint unsigned SPAN      = 4096,
   parameter int              TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AWIDTH-1:0]   addr,
   input  logic                wr,
   input  logic                rd,
   input  logic [DWIDTH-1:0]   wdata,
   input  logic [BE_WIDTH-1:0] byte_enable,
   input  logic                lock,
   output logic [DWIDTH-1:0]   rdata,
   output logic                rdata_valid,
   output response_te          response,
   output logic                wait_request,
   output logic [AWIDTH-1:0]   csr_addr,
   output logic                csr_wr,
   output logic                csr_rd,
   output logic [DWIDTH-1:0]   csr_wdata,
   output logic [BE_WIDTH-1:0] csr_be,
   input  logic [DWIDTH-1:0]   csr_rdata,
   input  logic                csr_ready,
   input  logic                csr_err
);

   if (!legal_dwidth(DWIDTH) || (BE_WIDTH != DWIDTH / 8)) begin : g_bad_width
      $fatal(1, "avalon_csr_bridge: illegal DWIDTH/BE_WIDTH combination");
   end

   localparam logic [AWIDTH:0] WIN_LO = BASE_ADDR[AWIDTH:0];
   localparam logic [AWIDTH:0] WIN_SZ = SPAN[AWIDTH:0];

   csr_bridge_state_te state;
   logic               is_rd;
   logic               tmo_expired;
   logic [AWIDTH+1:0]  offset;
   logic               in_window;
   logic               unused_lock;

   assign unused_lock = lock;

   // Offset computed with a spare sign bit so below-window addresses and a
   // window touching the top of the address space both decode correctly.
   assign offset    = {2'b00, addr} - {1'b0, WIN_LO};
   assign in_window = !offset[AWIDTH+1] && (offset[AWIDTH:0] < WIN_SZ);

   assign wait_request = (state != DONE);

`ifdef AVALON_CSR_TIMEOUT_EN
   avalon_csr_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .start   (state == ISSUE),
      .run     (state == WAIT),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         is_rd       <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         response    <= OKAY;
         csr_addr    <= '0;
         csr_wr      <= 1'b0;
         csr_rd      <= 1'b0;
         csr_wdata   <= '0;
         csr_be      <= '0;
      end else begin
         csr_wr      <= 1'b0;
         csr_rd      <= 1'b0;
         rdata_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (wr || rd) begin
                  csr_addr  <= offset[AWIDTH-1:0];
                  csr_wdata <= wdata;
                  csr_be    <= byte_enable;
                  is_rd     <= rd && !wr;
                  rdata     <= '0;
                  if (wr && rd) begin
                     state    <= DONE;
                     response <= SLAVE_ERROR;
                  end else if (!in_window) begin
                     state       <= DONE;
                     response    <= DECODE_ERROR;
                     rdata_valid <= rd;
                  end else if (wr && (byte_enable == '0)) begin
                     state    <= DONE;
                     response <= OKAY;
                  end else begin
                     state  <= ISSUE;
                     csr_wr <= wr;
                     csr_rd <= rd;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               // an acknowledge on the expiry cycle wins over the watchdog
               if (csr_ready) begin
                  state       <= DONE;
                  response    <= csr_err ? SLAVE_ERROR : OKAY;
                  rdata       <= (is_rd && !csr_err) ? csr_rdata : '0;
                  rdata_valid <= is_rd;
               end else if (tmo_expired) begin
                  state       <= DONE;
                  response    <= SLAVE_ERROR;
                  rdata       <= '0;
                  rdata_valid <= is_rd;
               end
            end
            DONE: begin
               state    <= IDLE;
               response <= OKAY;
               rdata    <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_csr_bridge.sv
// Self-checking bench for avalon_csr_bridge: directed scenarios plus random
// traffic checked against a word-array model of the register space.
module tb_avalon_csr_bridge;
   import avalon_bus_pkg::*;

   localparam int              AW   = 20;
   localparam int              DW   = 64;
   localparam int              BEW  = 8;
   localparam longint unsigned BASE = 64'h40000;
   localparam longint unsigned SPAN = 4096;
   localparam int              TMO  = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [AW-1:0]  addr = '0;
   logic           wr = 1'b0, rd = 1'b0, lock = 1'b0;
   logic [DW-1:0]  wdata = '0;
   logic [BEW-1:0] byte_enable = '0;
   logic [DW-1:0]  rdata;
   logic           rdata_valid;
   response_te     response;
   logic           wait_request;
   logic [AW-1:0]  csr_addr;
   logic           csr_wr, csr_rd;
   logic [DW-1:0]  csr_wdata;
   logic [BEW-1:0] csr_be;
   logic [DW-1:0]  csr_rdata = '0;
   logic           csr_ready = 1'b0, csr_err = 1'b0;

   always #5 clk = ~clk;

   avalon_csr_bridge #(
      .AWIDTH(AW), .DWIDTH(DW), .BE_WIDTH(BEW),
      .BASE_ADDR(BASE), .SPAN(SPAN), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
      .byte_enable(byte_enable), .lock(lock), .rdata(rdata),
      .rdata_valid(rdata_valid), .response(response),
      .wait_request(wait_request), .csr_addr(csr_addr), .csr_wr(csr_wr),
      .csr_rd(csr_rd), .csr_wdata(csr_wdata), .csr_be(csr_be),
      .csr_rdata(csr_rdata), .csr_ready(csr_ready), .csr_err(csr_err)
   );

   logic [DW-1:0] csr_mem [512];   // register block behind the bridge
   logic [DW-1:0] ref_mem [512];   // master's view, updated from stimulus
   int n_cmp = 0, n_bad = 0;

   int             o_done, o_strobes, o_rv_cnt;
   response_te     o_resp;
   logic [DW-1:0]  o_rdata, o_csr_wdata;
   logic [AW-1:0]  o_csr_addr;
   logic [BEW-1:0] o_csr_be;
   logic           o_was_wr;

   function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old,
         input logic [DW-1:0] nw, input logic [BEW-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < BEW; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // Drives one Avalon command and plays the CSR block; csr_ready comes
   // rdy_dly cycles after the strobe (negative: never), plus an optional
   // stray acknowledge at cycle spur. Cycle 0 is the command-sampling cycle.
   task automatic run_txn(input logic w, input logic r, input logic [AW-1:0] a,
         input logic [DW-1:0] d, input logic [BEW-1:0] be,
         input int rdy_dly, input bit err, input int spur);
      int c, s;
      c = 0; s = -1;
      o_done = -1; o_strobes = 0; o_rv_cnt = 0; o_rdata = 'x; o_resp = RESERVED;
      o_csr_addr = '0; o_csr_be = '0; o_csr_wdata = '0; o_was_wr = 1'b0;
      @(posedge clk); #1;
      wr = w; rd = r; addr = a; wdata = d; byte_enable = be;
      csr_ready = 1'b0; csr_err = 1'b0;
      while (o_done < 0 && c < 400) begin
         @(posedge clk); #1; c++;
         csr_ready = 1'b0; csr_err = 1'b0; csr_rdata = {$urandom, $urandom};
         if (rdata_valid) o_rv_cnt++;
         if (csr_wr || csr_rd) begin
            o_strobes++; s = c;
            o_csr_addr = csr_addr; o_csr_be = csr_be; o_csr_wdata = csr_wdata;
            o_was_wr = csr_wr;
            if (csr_wr && !err)
               csr_mem[csr_addr[11:3]] = be_merge(csr_mem[csr_addr[11:3]], csr_wdata, csr_be);
         end
         if (!wait_request) begin
            o_done = c; o_resp = response; o_rdata = rdata;
            wr = 1'b0; rd = 1'b0;
         end else if (c == spur) begin
            csr_ready = 1'b1; csr_err = 1'b1;
         end else if (s >= 0 && rdy_dly >= 0 && c == s + rdy_dly) begin
            csr_ready = 1'b1; csr_err = err;
            csr_rdata = csr_mem[o_csr_addr[11:3]];
         end
      end
      wr = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      csr_ready = 1'b0; csr_err = 1'b0;
      if (rdata_valid) o_rv_cnt++;
      if (o_done < 0) begin
         rst = 1'b0; #1 rst = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({wait_request, csr_wr, csr_rd, rdata_valid, response, rdata, csr_addr, csr_wdata, csr_be}
          !== {1'b1, 3'b000, OKAY, 64'h0, 20'h0, 64'h0, 8'h0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got wreq=%b wr=%b rd=%b rv=%b resp=%0d rdata=%h caddr=%h",
                  wait_request, csr_wr, csr_rd, rdata_valid, response, rdata, csr_addr);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_write;
      logic [DW-1:0] d;
      d = 64'hDEADBEEF_01234567;
      run_txn(1'b1, 1'b0, AW'(BASE + 'h10), d, 8'hFF, 1, 1'b0, -1);
      ref_mem[2] = d;
      n_cmp++; if (o_strobes !== 1 || o_was_wr !== 1'b1) begin n_bad++; $display("FAIL wr_strobe: got %0d wr=%b exp 1 wr=1", o_strobes, o_was_wr); end
      n_cmp++; if (o_csr_addr !== 20'h10) begin n_bad++; $display("FAIL wr_csr_addr: got %h exp 10", o_csr_addr); end
      n_cmp++; if (o_csr_wdata !== d || o_csr_be !== 8'hFF) begin n_bad++; $display("FAIL wr_csr_data: got %h/%h exp %h/ff", o_csr_wdata, o_csr_be, d); end
      n_cmp++; if (o_done !== 3) begin n_bad++; $display("FAIL wr_done_cycle: got %0d exp 3", o_done); end
      n_cmp++; if (o_resp !== OKAY) begin n_bad++; $display("FAIL wr_resp: got %0d exp %0d", o_resp, OKAY); end
   endtask

   task automatic test_read_late;
      csr_mem[1] = 64'h55AA; ref_mem[1] = 64'h55AA;
      run_txn(1'b0, 1'b1, AW'(BASE + 'h8), '0, 8'hFF, 5, 1'b0, -1);
      n_cmp++; if (o_rdata !== 64'h55AA) begin n_bad++; $display("FAIL rd_data: got %h exp 55aa", o_rdata); end
      n_cmp++; if (o_rv_cnt !== 1) begin n_bad++; $display("FAIL rd_valid_cycles: got %0d exp 1", o_rv_cnt); end
      n_cmp++; if (o_resp !== OKAY) begin n_bad++; $display("FAIL rd_resp: got %0d exp %0d", o_resp, OKAY); end
      n_cmp++; if (o_done + 1 !== 8) begin n_bad++; $display("FAIL rd_latency: got %0d exp 8", o_done + 1); end
   endtask

   task automatic test_decode;
      run_txn(1'b0, 1'b1, AW'(BASE + SPAN), '0, 8'hFF, 1, 1'b0, -1);
      n_cmp++; if (o_strobes !== 0) begin n_bad++; $display("FAIL dec_hi_strobe: got %0d exp 0", o_strobes); end
      n_cmp++; if (o_resp !== DECODE_ERROR || o_rdata !== '0) begin n_bad++; $display("FAIL dec_hi_resp: got %0d/%h exp %0d/0", o_resp, o_rdata, DECODE_ERROR); end
      n_cmp++; if (o_done !== 1) begin n_bad++; $display("FAIL dec_hi_cycle: got %0d exp 1", o_done); end
      run_txn(1'b1, 1'b0, AW'(BASE - 8), 64'h1, 8'hFF, 1, 1'b0, -1);
      n_cmp++; if (o_strobes !== 0 || o_resp !== DECODE_ERROR) begin n_bad++; $display("FAIL dec_lo: got strobes=%0d resp=%0d exp 0/%0d", o_strobes, o_resp, DECODE_ERROR); end
      run_txn(1'b0, 1'b1, AW'(BASE + SPAN - 8), '0, 8'hFF, 1, 1'b0, -1);
      n_cmp++; if (o_strobes !== 1 || o_resp !== OKAY || o_rdata !== ref_mem[511]) begin n_bad++; $display("FAIL dec_last_word: got strobes=%0d resp=%0d rdata=%h exp 1/0/%h", o_strobes, o_resp, o_rdata, ref_mem[511]); end
   endtask

   task automatic test_illegal;
      run_txn(1'b1, 1'b1, AW'(BASE + 'h18), 64'h77, 8'hFF, 1, 1'b0, -1);
      n_cmp++; if (o_strobes !== 0) begin n_bad++; $display("FAIL illegal_strobe: got %0d exp 0", o_strobes); end
      n_cmp++; if (o_resp !== SLAVE_ERROR || o_rdata !== '0 || o_done !== 1) begin n_bad++; $display("FAIL illegal_resp: got %0d/%h/%0d exp %0d/0/1", o_resp, o_rdata, o_done, SLAVE_ERROR); end
   endtask

   task automatic test_empty_be;
      run_txn(1'b1, 1'b0, AW'(BASE + 'h20), 64'hFFFF, 8'h00, 1, 1'b0, -1);
      n_cmp++; if (o_strobes !== 0 || o_resp !== OKAY || o_done !== 1) begin n_bad++; $display("FAIL empty_be: got strobes=%0d resp=%0d done=%0d exp 0/0/1", o_strobes, o_resp, o_done); end
   endtask

   task automatic test_csr_err;
      run_txn(1'b0, 1'b1, AW'(BASE + 'h28), '0, 8'hFF, 2, 1'b1, -1);
      n_cmp++; if (o_resp !== SLAVE_ERROR || o_rdata !== '0) begin n_bad++; $display("FAIL csr_err: got %0d/%h exp %0d/0", o_resp, o_rdata, SLAVE_ERROR); end
      n_cmp++; if (o_rv_cnt !== 1 || o_done !== 4) begin n_bad++; $display("FAIL csr_err_timing: got rv=%0d done=%0d exp 1/4", o_rv_cnt, o_done); end
   endtask

   // A stray error acknowledge during ISSUE must not end the transaction.
   task automatic test_spurious_ready;
      run_txn(1'b0, 1'b1, AW'(BASE + 'h8), '0, 8'hFF, 3, 1'b0, 1);
      n_cmp++; if (o_done !== 5 || o_resp !== OKAY || o_rdata !== ref_mem[1]) begin n_bad++; $display("FAIL spurious_ready: got done=%0d resp=%0d rdata=%h exp 5/0/%h", o_done, o_resp, o_rdata, ref_mem[1]); end
   endtask

`ifdef AVALON_CSR_TIMEOUT_EN
   task automatic test_timeout;
      run_txn(1'b0, 1'b1, AW'(BASE + 'h8), '0, 8'hFF, -1, 1'b0, -1);
      n_cmp++; if (o_done !== 2 + TMO || o_resp !== SLAVE_ERROR || o_rdata !== '0) begin n_bad++; $display("FAIL timeout_expire: got done=%0d resp=%0d rdata=%h exp %0d/%0d/0", o_done, o_resp, o_rdata, 2 + TMO, SLAVE_ERROR); end
      run_txn(1'b0, 1'b1, AW'(BASE + 'h8), '0, 8'hFF, TMO, 1'b0, -1);
      n_cmp++; if (o_done !== 2 + TMO || o_resp !== OKAY || o_rdata !== ref_mem[1]) begin n_bad++; $display("FAIL timeout_ready_wins: got done=%0d resp=%0d rdata=%h exp %0d/0/%h", o_done, o_resp, o_rdata, 2 + TMO, ref_mem[1]); end
   endtask
`else
   task automatic test_timeout;
      run_txn(1'b0, 1'b1, AW'(BASE + 'h8), '0, 8'hFF, 3 * TMO, 1'b0, -1);
      n_cmp++; if (o_done !== 2 + 3 * TMO || o_resp !== OKAY || o_rdata !== ref_mem[1]) begin n_bad++; $display("FAIL wait_hold: got done=%0d resp=%0d rdata=%h exp %0d/0/%h", o_done, o_resp, o_rdata, 2 + 3 * TMO, ref_mem[1]); end
   endtask
`endif

   // Command held continuously with csr_ready stuck high: a second strobe
   // must follow one IDLE cycle after DONE.
   task automatic test_back_to_back;
      logic [7:0] wq_pat, st_pat;
      @(posedge clk); #1;
      wr = 1'b1; addr = AW'(BASE + 'h30); wdata = {$urandom, $urandom}; byte_enable = 8'hFF;
      csr_ready = 1'b1; csr_err = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         wq_pat[c-1] = wait_request; st_pat[c-1] = csr_wr;
      end
      wr = 1'b0; csr_ready = 1'b0;
      csr_mem[6] = wdata; ref_mem[6] = wdata;
      @(posedge clk); #1;
      n_cmp++; if (wq_pat !== 8'hBB) begin n_bad++; $display("FAIL b2b_wait_request: got %b exp 10111011", wq_pat); end
      n_cmp++; if (st_pat !== 8'h11) begin n_bad++; $display("FAIL b2b_strobes: got %b exp 00010001", st_pat); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      rd = 1'b1; addr = AW'(BASE + 'h20); wdata = 64'hA5A5; byte_enable = 8'h0F;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if ({wait_request, csr_wr, csr_rd, rdata_valid, response, rdata, csr_addr, csr_wdata, csr_be}
          !== {1'b1, 3'b000, OKAY, 64'h0, 20'h0, 64'h0, 8'h0}) begin
         n_bad++;
         $display("FAIL reset_mid: got wreq=%b rv=%b resp=%0d caddr=%h cwdata=%h cbe=%h",
                  wait_request, rdata_valid, response, csr_addr, csr_wdata, csr_be);
      end
      rd = 1'b0;
      @(posedge clk); #3 rst = 1'b1;
      run_txn(1'b1, 1'b0, AW'(BASE + 'h40), 64'h0BAD_F00D, 8'hFF, 1, 1'b0, -1);
      ref_mem[8] = 64'h0BAD_F00D;
      n_cmp++; if (o_done !== 3 || o_resp !== OKAY || o_strobes !== 1 || o_csr_addr !== 20'h40) begin n_bad++; $display("FAIL reset_recover: got done=%0d resp=%0d strobes=%0d caddr=%h exp 3/0/1/40", o_done, o_resp, o_strobes, o_csr_addr); end
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         bit w, oow, err;
         int word, dly;
         logic [AW-1:0] a;
         logic [DW-1:0] d, exp_rdata;
         logic [BEW-1:0] be;
         response_te exp_resp;
         int exp_strobes, exp_done;
         w    = $urandom_range(0, 1);
         oow  = ($urandom_range(0, 9) == 0);
         err  = ($urandom_range(0, 5) == 0);
         word = $urandom_range(0, 511);
         dly  = $urandom_range(1, 6);
         d    = {$urandom, $urandom};
         be   = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom);
         if (!oow)                         a = AW'(BASE + word * 8);
         else if ($urandom_range(0, 1)) a = AW'(BASE + SPAN + word * 8);
         else                              a = AW'(BASE - 8 - word * 8);
         exp_rdata = '0;
         if (oow) begin
            exp_resp = DECODE_ERROR; exp_strobes = 0; exp_done = 1;
         end else if (w && be == '0) begin
            exp_resp = OKAY; exp_strobes = 0; exp_done = 1;
         end else begin
            exp_resp = err ? SLAVE_ERROR : OKAY; exp_strobes = 1; exp_done = dly + 2;
            if (!w && !err) exp_rdata = ref_mem[word];
         end
         run_txn(w, !w, a, d, be, dly, err, -1);
         if (!oow && w && be != '0 && !err) ref_mem[word] = be_merge(ref_mem[word], d, be);
         n_cmp++; if (o_resp !== exp_resp) begin n_bad++; $display("FAIL rand%0d_resp: got %0d exp %0d", n, o_resp, exp_resp); end
         n_cmp++; if (o_rdata !== exp_rdata) begin n_bad++; $display("FAIL rand%0d_rdata: got %h exp %h", n, o_rdata, exp_rdata); end
         n_cmp++; if (o_strobes !== exp_strobes || o_done !== exp_done) begin n_bad++; $display("FAIL rand%0d_timing: got strobes=%0d done=%0d exp %0d/%0d", n, o_strobes, o_done, exp_strobes, exp_done); end
         n_cmp++; if (o_rv_cnt !== (w ? 0 : 1)) begin n_bad++; $display("FAIL rand%0d_rvalid: got %0d exp %0d", n, o_rv_cnt, w ? 0 : 1); end
         if (exp_strobes == 1) begin
            n_cmp++; if (o_csr_addr !== AW'(word * 8) || o_was_wr !== w) begin n_bad++; $display("FAIL rand%0d_csr: got addr=%h wr=%b exp %h/%b", n, o_csr_addr, o_was_wr, AW'(word * 8), w); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         csr_mem[i] = {$urandom, $urandom};
         ref_mem[i] = csr_mem[i];
      end
      test_reset;
      test_write;
      test_read_late;
      test_decode;
      test_illegal;
      test_empty_be;
      test_csr_err;
      test_spurious_ready;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/avalon_csr_bridge.md
# avalon_csr_bridge

Avalon-MM slave-side bridge between the NIOS `avalon_bus` interconnect and a generated CSR register block. It accepts one Avalon read or write at a time, decodes it against an address window, and issues a single-cycle register strobe. It returns rdata and a `response_te` status to the master, stalling with `wait_request` until the CSR block acknowledges, reports an error, or times out.

## Interface
- `AWIDTH`, 20: Avalon address width.
- `DWIDTH`, 64: data width; legal values are 8, 16, 32, 64 and 128.
- `BE_WIDTH`, `DWIDTH/8`: byte-enable width.
- `BASE_ADDR`, 0: first byte address of the decode window.
- `SPAN`, 4096: window size in bytes.
- `TIMEOUT`, 255: maximum number of WAIT cycles before a forced SLAVE_ERROR.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `addr` in AWIDTH: Avalon byte address.
- `wr` / `rd` in 1: Avalon write / read command.
- `wdata` in DWIDTH: write data.
- `byte_enable` in BE_WIDTH: byte lanes.
- `lock` in 1: accepted and ignored; there is a single slave behind the bridge.
- `rdata` out DWIDTH: read data, valid while `rdata_valid` is high.
- `rdata_valid` out 1: read completion strobe.
- `response` out `response_te`: completion status.
- `wait_request` out 1: stall to the master.
- `csr_addr` out AWIDTH: `addr - BASE_ADDR`, registered.
- `csr_wr` / `csr_rd` out 1: single-cycle register strobes.
- `csr_wdata` out DWIDTH: registered write data.
- `csr_be` out BE_WIDTH: registered byte enables.
- `csr_rdata` in DWIDTH: register read data, sampled with `csr_ready`.
- `csr_ready` in 1: CSR block acknowledge.
- `csr_err` in 1: CSR block error, qualified by `csr_ready`.

## Operation
State machine: IDLE, ISSUE, WAIT, DONE.

- **IDLE**
  - No command: stay in IDLE.
  - If `wr|rd` is high, capture addr, wdata and byte_enable.
  - `wr&rd` both high: go to DONE with SLAVE_ERROR; no strobe is issued.
  - Address outside `[BASE_ADDR, BASE_ADDR+SPAN)`: go to DONE with DECODE_ERROR.
  - Write with `byte_enable==0`: go to DONE with OKAY; no strobe is issued.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `csr_wr` or `csr_rd` is high for exactly this cycle.
  - Next state is WAIT.
- **WAIT**
  - `csr_ready` high: capture `csr_rdata` for reads and set response to `csr_err ? SLAVE_ERROR : OKAY`; go to DONE.
  - `csr_ready` is ignored in every other state.
- **DONE**
  - `wait_request` low; the Avalon command completes this cycle.
  - Reads: `rdata_valid=1` and `rdata` is driven.
  - `response` is valid.
  - Next state is IDLE.
- **Read data on error:** every error completion returns `rdata=0`.
- **Aborted commands:** if the master drops `wr/rd` before DONE (an Avalon protocol violation), the transaction still completes and the DONE cycle is still driven.
- **Decode arithmetic:** computed in AWIDTH+1 bits, so `BASE_ADDR+SPAN` at the top of the address space does not wrap.
- **Reset mid-transaction:** asynchronous return to IDLE. All strobes are low, `wait_request=1`, `rdata=0`, `rdata_valid=0`, `response=OKAY`, `csr_addr/csr_wdata/csr_be=0`.

## Timing
- `wait_request = (state != DONE)`, decoded from registered state with no input-to-output path. It is high during reset.
- Successful access when `csr_ready` arrives in the first WAIT cycle:
  - Command sampled in cycle 0; strobe in cycle 1; `csr_ready` in cycle 2; DONE in cycle 3.
  - Minimum latency is 4 cycles.
- Decode, illegal-command and empty-byte-enable completions: DONE in cycle 1.
- Back-to-back commands: the next command is sampled in IDLE, at the earliest one cycle after DONE.
- All outputs are registered or decoded from registered state.

## Configuration
- `AVALON_CSR_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no `csr_ready`, go to DONE with SLAVE_ERROR and `rdata=0`.
  - A `csr_ready` in the same cycle as expiry takes priority.
- `AVALON_CSR_TIMEOUT_EN` undefined: no counter; WAIT holds indefinitely.

## Structure
- `avalon_bus_pkg` holds:
  - the existing `response_te`;
  - a new `csr_bridge_state_te` typedef (IDLE, ISSUE, WAIT, DONE);
  - a `legal_dwidth()` constant function used for the elaboration-time `$fatal` on DWIDTH and BE_WIDTH.
- Sub-module `avalon_csr_timeout`: counter of width `$clog2(TIMEOUT+1)`, with `start`/`expired` ports. It is instantiated only under `AVALON_CSR_TIMEOUT_EN`.

## Test plan
- Write `addr=BASE_ADDR+0x10`, `wdata=0xDEADBEEF_01234567`, `byte_enable=0xFF`; CSR acknowledges 1 cycle after the strobe → one `csr_wr` pulse with `csr_addr=0x10`, `wait_request` low in cycle 3, `response=OKAY`.
- Read `addr=BASE_ADDR+0x8`; CSR returns `0x55AA` with `csr_ready` 5 cycles late → `rdata=0x55AA`, `rdata_valid` for 1 cycle, OKAY, latency 8 cycles.
- Read `addr=BASE_ADDR+SPAN` → no strobe, DECODE_ERROR, `rdata=0`, `wait_request` low in cycle 1.
- `wr` and `rd` both high → SLAVE_ERROR and no strobe. Read with `csr_err=1` alongside `csr_ready` → SLAVE_ERROR, `rdata=0`.
- Timeout (macro on, `TIMEOUT=16`): read with CSR never ready → SLAVE_ERROR after 16 WAIT cycles. In a separate run, `csr_ready` on the expiry cycle → OKAY.
- Assert `rst` low during WAIT → all outputs at their reset values immediately. After release, a fresh write completes normally.
